// File: rtl/trig_output_buffer.sv
// Trigger-word output FIFO (first-word-fall-through) that never back-pressures the generator.
// While the FIFO is full, incoming beats are dropped and counted, and one marker word is queued once room frees up.
module trig_output_buffer #(
    parameter int unsigned FIFO_DEPTH = 16
) (
    input  logic                          ifclk,
    input  logic                          rst_i,
    input  logic [31:0]                   s_trig_tdata,
    input  logic                          s_trig_tvalid,
    output logic                          s_trig_tready,
    output logic [31:0]                   m_trig_tdata,
    output logic                          m_trig_tvalid,
    input  logic                          m_trig_tready,
    output logic [$clog2(FIFO_DEPTH):0]   occupancy_o,
    output logic [$clog2(FIFO_DEPTH):0]   hwm_o,
    input  logic                          hwm_clr_i,
    output logic [31:0]                   drop_total_o,
    output logic                          overflow_o
);

    localparam int unsigned AW      = $clog2(FIFO_DEPTH);
    localparam int unsigned CW      = AW + 1;
    localparam logic [15:0] RUN_MAX = 16'hFFFF;

    typedef enum logic {
        NORMAL   = 1'b0,
        DROPPING = 1'b1
    } state_t;

    state_t         state_q, state_d;
    logic [15:0]    run_q, run_d;
    logic [31:0]    mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]  count_q, count_d;
    logic [CW-1:0]  hwm_q, hwm_d;
    logic [31:0]    drop_q;
    logic           ready_q;
    logic           tvalid_q;
    logic           overflow_q;

    logic           full;
    logic           beat;
    logic           pop;
    logic           wr_en;
    logic           drop;
    logic [31:0]    wr_data;
    logic [15:0]    run_inc;

    // Count is sampled at the start of the cycle: a same-cycle pop never frees room for a write.
    assign full    = (count_q == CW'(FIFO_DEPTH));
    assign beat    = s_trig_tvalid & ready_q;
    assign pop     = tvalid_q & m_trig_tready;
    assign run_inc = (run_q == RUN_MAX) ? RUN_MAX : run_q + 16'd1;

    // Next state, run length and write/drop decisions.
    always_comb begin
        state_d = state_q;
        run_d   = run_q;
        wr_en   = 1'b0;
        drop    = 1'b0;
        wr_data = s_trig_tdata;
        case (state_q)
            NORMAL: begin
                if (beat) begin
                    if (full) begin
                        drop    = 1'b1;
                        state_d = DROPPING;
                        run_d   = 16'd1;
                    end else begin
                        wr_en = 1'b1;
                    end
                end
            end
            DROPPING: begin
                if (full) begin
                    if (beat) begin
                        drop  = 1'b1;
                        run_d = run_inc;
                    end
                end else begin
                    // Marker closes the run; a beat arriving in this same cycle is still counted as dropped.
                    wr_en   = 1'b1;
                    wr_data = {RUN_MAX, (beat ? run_inc : run_q)};
                    drop    = beat;
                    state_d = NORMAL;
                    run_d   = 16'd0;
                end
            end
        endcase
    end

    // Occupancy and high-water mark bookkeeping.
    always_comb begin
        count_d = count_q;
        case ({wr_en, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        if (hwm_clr_i) begin
            hwm_d = count_d;
        end else if (count_d > hwm_q) begin
            hwm_d = count_d;
        end else begin
            hwm_d = hwm_q;
        end
    end

    always_ff @(posedge ifclk) begin
        if (rst_i) begin
            state_q    <= NORMAL;
            run_q      <= 16'd0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            hwm_q      <= '0;
            drop_q     <= 32'd0;
            ready_q    <= 1'b0;
            tvalid_q   <= 1'b0;
            overflow_q <= 1'b0;
            for (int i = 0; i < int'(FIFO_DEPTH); i++) begin
                mem[i] <= 32'd0;
            end
        end else begin
            state_q    <= state_d;
            run_q      <= run_d;
            count_q    <= count_d;
            hwm_q      <= hwm_d;
            ready_q    <= 1'b1;
            tvalid_q   <= (count_d != '0);
            overflow_q <= (state_d == DROPPING);
            if (drop) begin
                drop_q <= drop_q + 32'd1;
            end
            if (wr_en) begin
                mem[wr_ptr_q] <= wr_data;
                wr_ptr_q      <= wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
        end
    end

    assign s_trig_tready = ready_q;
    assign m_trig_tvalid = tvalid_q;
    assign m_trig_tdata  = mem[rd_ptr_q];
    assign occupancy_o   = count_q;
    assign hwm_o         = hwm_q;
    assign drop_total_o  = drop_q;
    assign overflow_o    = overflow_q;

endmodule

// File: doc/trig_output_buffer.md
TRIG_OUTPUT_BUFFER -- requirements
Module: trig_output_buffer

Interface
REQ-001 Parameter FIFO_DEPTH, default 16, sets the number of trigger-word entries; it SHALL be a power of two, at least 4.
REQ-002 Port ifclk, input, 1 bit: the single clock; all logic SHALL be clocked on its rising edge.
REQ-003 Port rst_i, input, 1 bit: the reset, synchronous and active-high.
REQ-004 Ports s_trig_tdata (input, 32), s_trig_tvalid (input, 1) and s_trig_tready (output, 1) SHALL form the AXI4-Stream input that takes trigger words from the generator stream.
REQ-005 Ports m_trig_tdata (output, 32), m_trig_tvalid (output, 1) and m_trig_tready (input, 1) SHALL form the AXI4-Stream output towards the link.
REQ-006 Port occupancy_o, output, clog2(FIFO_DEPTH)+1 bits: current FIFO entry count.
REQ-007 Port hwm_o, output, same width as occupancy_o: high-water mark of occupancy.
REQ-008 Port hwm_clr_i, input, 1 bit: a one-cycle pulse that clears the high-water mark.
REQ-009 Port drop_total_o, output, 32 bits: cumulative count of dropped trigger words.
REQ-010 Port overflow_o, output, 1 bit: high while the state machine is in DROPPING.

Function
REQ-011 s_trig_tready SHALL be 1 in every cycle after reset, so the block never back-pressures the generator.
REQ-012 Beat acceptance: a word SHALL be written to the FIFO when s_trig_tvalid=1, state=NORMAL and count<FIFO_DEPTH, with count sampled at the start of the cycle.
REQ-013 A pop in the same cycle SHALL NOT create room for a write; with count==FIFO_DEPTH the incoming beat is dropped.
REQ-014 The FIFO SHALL be first-word-fall-through: m_trig_tvalid = (count>0), and m_trig_tdata = the oldest entry.
REQ-015 A pop SHALL occur when m_trig_tvalid and m_trig_tready are both 1.
REQ-016 Latency: a word written in cycle N SHALL be presented on m_trig_* from cycle N+1 when the FIFO was empty.
REQ-017 Word order SHALL be preserved, and m_trig_tdata SHALL stay stable while m_trig_tvalid=1 and m_trig_tready=0.
REQ-018 count SHALL update by +1 on write only, -1 on pop only, and by 0 on simultaneous write and pop.
REQ-019 Read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-020 The state machine SHALL have exactly two states, NORMAL and DROPPING.
REQ-021 NORMAL -> DROPPING SHALL occur on the first dropped beat.
REQ-022 On a NORMAL -> DROPPING transition, run_cnt SHALL be set to 1.
REQ-023 In DROPPING with count==FIFO_DEPTH: each valid beat SHALL be dropped, run_cnt SHALL increment and saturate at 16'hFFFF, and the state SHALL stay DROPPING.
REQ-024 In DROPPING with count<FIFO_DEPTH, the marker {16'hFFFF, run_cnt'} SHALL be written to the FIFO.
REQ-025 run_cnt' SHALL equal run_cnt+1 (saturating) if a valid beat arrives that cycle, otherwise run_cnt; that beat is dropped.
REQ-026 After the marker write, the state SHALL go to NORMAL and run_cnt SHALL clear to 0.
REQ-027 A marker write SHALL obey the same count, pointer and pop rules as a data write.
REQ-028 Words with tdata[31:16]==16'hFFFF are reserved for markers; the block SHALL NOT check incoming data for this pattern.
REQ-029 drop_total_o SHALL increment by 1 for each dropped beat and wrap at 2^32.
REQ-030 hwm_o SHALL update each cycle to max(hwm_o, next count).
REQ-031 On hwm_clr_i=1, hwm_o SHALL load the next count instead; clear takes priority over the max update.
REQ-032 occupancy_o, hwm_o and overflow_o SHALL be registered values.

Reset
REQ-033 While rst_i=1 at a clock edge, the block SHALL set: count=0, pointers=0, state=NORMAL, run_cnt=0, drop_total_o=0, hwm_o=0, s_trig_tready=0, m_trig_tvalid=0, overflow_o=0.
REQ-034 m_trig_tdata SHALL be 0 after reset until the first write.
REQ-035 Reset asserted mid-operation SHALL discard FIFO contents and any pending marker, and no marker SHALL be emitted for a pre-reset drop run.
REQ-036 s_trig_tready SHALL return to 1 in the first cycle after rst_i deasserts.

Verification
REQ-037 Pass-through: with m_trig_tready=1, write 0x00000001, 0x00000002, 0x00000003 back-to-back -> the same words appear in order starting 1 cycle later; occupancy never exceeds 1; drop_total_o=0.
REQ-038 Overflow and marker: with m_trig_tready=0, send 16 words, then 3 more, then raise m_trig_tready -> overflow_o=1 after the 17th beat; the 16 words drain, then marker 0xFFFF0003 appears; drop_total_o=3; hwm_o=16.
REQ-039 Same-cycle drop: with the FIFO full and in DROPPING, pop one entry and present a beat in the next cycle -> the beat is dropped and the marker carries run_cnt+1; state returns to NORMAL.
REQ-040 Saturation: hold the FIFO full for 70000 valid beats, then drain -> the marker equals 0xFFFFFFFF and drop_total_o=70000.
REQ-041 Reset mid-run: assert rst_i for one cycle in DROPPING with 16 entries queued -> afterwards m_trig_tvalid=0, occupancy_o=0, drop_total_o=0, and no marker is ever output.
REQ-042 HWM clear: fill to 5 entries, drain to 2, pulse hwm_clr_i -> hwm_o reads 5 before the pulse and 2 after it.
